// File: rtl/io_seq_checker_if.sv
// Bus bundle for io_seq_checker: pad-side status field, expected-list
// programming, control pulses and the verdict outputs.
interface io_seq_checker_if #(
  parameter int FIELD_W = 5,
  parameter int DEPTH   = 8,
  parameter int TMO_W   = 24
);
  localparam int AW = $clog2(DEPTH);

  logic [FIELD_W-1:0] field_i;
  logic               exp_we_i;
  logic [AW-1:0]      exp_addr_i;
  logic [FIELD_W-1:0] exp_data_i;
  logic [AW:0]        seq_len_i;
  logic [TMO_W-1:0]   tmo_i;
  logic               start_i;
  logic               abort_i;
  logic               busy_o;
  logic               pass_o;
  logic               fail_o;
  logic [1:0]         fail_code_o;
  logic [AW-1:0]      step_o;

  modport master (
    output field_i, exp_we_i, exp_addr_i, exp_data_i, seq_len_i, tmo_i, start_i, abort_i,
    input  busy_o, pass_o, fail_o, fail_code_o, step_o
  );

  modport slave (
    input  field_i, exp_we_i, exp_addr_i, exp_data_i, seq_len_i, tmo_i, start_i, abort_i,
    output busy_o, pass_o, fail_o, fail_code_o, step_o
  );
endinterface

// File: rtl/io_seq_checker.sv
// io_seq_checker: steps a synchronised status field through a programmed list
// of expected values, each of which must hold STABLE_N cycles, with an
// optional per-step timeout. Verdict is sticky until the next start.
// Optional feature: define IO_SEQ_CHK_STRICT_EN to fail (code 11) on a stable
// value that is neither the awaited entry nor the previously matched one.
module io_seq_checker #(
  parameter int FIELD_W  = 5,
  parameter int DEPTH    = 8,
  parameter int STABLE_N = 2,
  parameter int TMO_W    = 24
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  io_seq_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STABLE_N + 1);

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;

  state_t             state, state_nx;
  logic [FIELD_W-1:0] exp_mem [DEPTH];
  logic [FIELD_W-1:0] field_p0, field_p1;
  logic [SW-1:0]      stab_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [AW-1:0]      step;
  logic [LW-1:0]      seq_len;
  logic               pass, fail;
  logic [1:0]         fail_code;
  logic               len_bad, eq, match, last, timeout, illegal;

  // Saturating increment for the run-length counters.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(STABLE_N)) ? SW'(STABLE_N) : v + SW'(1);
  endfunction

  assign len_bad = (bus.seq_len_i == '0) || (bus.seq_len_i > LW'(DEPTH));
  assign eq      = (field_p1 == exp_mem[step]);
  assign match   = (state == ARMED) && eq && (stab_cnt == SW'(STABLE_N - 1));
  assign last    = ({1'b0, step} == seq_len - LW'(1));
  assign timeout = (state == ARMED) && (bus.tmo_i != '0) && (tmo_cnt == bus.tmo_i);

`ifdef IO_SEQ_CHK_STRICT_EN
  logic [FIELD_W-1:0] field_p2;
  logic [SW-1:0]      run_cnt, run_now;

  assign run_now = (field_p1 == field_p2) ? sat_inc(run_cnt) : SW'(1);

  // How long the synced value has held, regardless of the expected list.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      field_p2 <= '0;
      run_cnt  <= '0;
    end else begin
      field_p2 <= field_p1;
      run_cnt  <= run_now;
    end
  end

  // Entry 0 is awaited with no prior match, so anything is tolerated until then.
  assign illegal = (state == ARMED) && (step != '0) && (run_now >= SW'(STABLE_N)) &&
                   !eq && (field_p1 != exp_mem[step - AW'(1)]);
`else
  assign illegal = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous pad field.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      field_p0 <= '0;
      field_p1 <= '0;
    end else begin
      field_p0 <= bus.field_i;
      field_p1 <= field_p0;
    end
  end

  // Expected-list RAM; the list is frozen while a check is armed.
  always_ff @(posedge wb_clk_i) begin
    if (bus.exp_we_i && (state != ARMED)) exp_mem[bus.exp_addr_i] <= bus.exp_data_i;
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state: abort beats start, start beats in-flight events, match beats timeout.
  always_comb begin
    state_nx = state;
    if (bus.abort_i) begin
      state_nx = IDLE;
    end else if (bus.start_i) begin
      state_nx = len_bad ? FAIL : ARMED;
    end else if (state == ARMED) begin
      if (match) begin
        if (last) state_nx = PASS;
      end else if (timeout || illegal) begin
        state_nx = FAIL;
      end
    end
  end

  // Output decode.
  always_comb begin
    bus.busy_o      = (state == ARMED);
    bus.pass_o      = pass;
    bus.fail_o      = fail;
    bus.fail_code_o = fail_code;
    bus.step_o      = step;
  end

  // Step, counters and sticky verdict; same priority order as the next-state logic.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      step      <= '0;
      seq_len   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'b00;
    end else if (bus.abort_i) begin
      stab_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (bus.start_i) begin
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      step      <= '0;
      seq_len   <= bus.seq_len_i;
      pass      <= 1'b0;
      fail      <= len_bad;
      fail_code <= len_bad ? 2'b10 : 2'b00;
    end else if (state == ARMED) begin
      if (match) begin
        stab_cnt <= '0;
        tmo_cnt  <= '0;
        if (last) pass <= 1'b1;
        else      step <= step + AW'(1);
      end else if (timeout) begin
        fail      <= 1'b1;
        fail_code <= 2'b01;
      end else if (illegal) begin
        fail      <= 1'b1;
        fail_code <= 2'b11;
      end else begin
        stab_cnt <= eq ? sat_inc(stab_cnt) : '0;
        tmo_cnt  <= tmo_cnt + TMO_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_io_seq_checker.sv
// Bench for io_seq_checker: directed scenarios followed by randomized
// expected lists and field waveforms, all scored against a per-cycle
// reference derived from the matching rules.
module tb_io_seq_checker;
  localparam int FIELD_W  = 5;
  localparam int DEPTH    = 8;
  localparam int STABLE_N = 2;
  localparam int TMO_W    = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_seq_checker_if #(.FIELD_W(FIELD_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) bus ();

  io_seq_checker #(.FIELD_W(FIELD_W), .DEPTH(DEPTH), .STABLE_N(STABLE_N), .TMO_W(TMO_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int                 n_cmp = 0;
  int                 n_bad = 0;
  logic [FIELD_W-1:0] hist [$];     // field value present at each clock edge
  logic [FIELD_W-1:0] mexp [DEPTH]; // reference copy of the expected list
  logic [FIELD_W-1:0] drv [$];      // field waveform to apply after start
  logic [FIELD_W-1:0] cur = '0;

  task automatic tick(input logic [FIELD_W-1:0] v);
    bus.field_i = v;
    cur = v;
    @(posedge clk);
    hist.push_back(v);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // True when the field was identical for the STABLE_N edges ending at edge j.
  function automatic bit held(input int j);
    for (int i = 1; i < STABLE_N; i++)
      if (j - i < 0 || hist[j - i] != hist[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference verdict after n edges following the start edge s.
  function automatic void model(input int s, input int n, input int len, input int tmo,
                                output logic busy, output logic pass, output logic fail,
                                output logic [1:0] code, output int step);
    int run, t;
    logic [FIELD_W-1:0] v;
    busy = 1'b1; pass = 1'b0; fail = 1'b0; code = 2'd0; step = 0;
    if (len == 0 || len > DEPTH) begin
      busy = 1'b0; fail = 1'b1; code = 2'd2;
      return;
    end
    run = 0; t = 0;
    for (int k = 1; k <= n; k++) begin
      v = hist[s + k - 2];   // the match logic sees the field two edges late
      run = (v == mexp[step]) ? run + 1 : 0;
      if (run == STABLE_N) begin
        run = 0; t = 0;
        if (step == len - 1) begin
          busy = 1'b0; pass = 1'b1;
          return;
        end
        step++;
      end else if (tmo != 0 && t == tmo) begin
        busy = 1'b0; fail = 1'b1; code = 2'd1;
        return;
      end
`ifdef IO_SEQ_CHK_STRICT_EN
      else if (step != 0 && held(s + k - 2) && v != mexp[step] && v != mexp[step - 1]) begin
        busy = 1'b0; fail = 1'b1; code = 2'd3;
        return;
      end
`endif
      else t++;
    end
  endfunction

  task automatic abort_pulse();
    bus.abort_i = 1'b1;
    tick(cur);
    bus.abort_i = 1'b0;
  endtask

  task automatic load_all();
    abort_pulse();
    for (int i = 0; i < DEPTH; i++) begin
      bus.exp_we_i   = 1'b1;
      bus.exp_addr_i = 3'(i);
      bus.exp_data_i = mexp[i];
      tick(cur);
    end
    bus.exp_we_i = 1'b0;
  endtask

  task automatic push_n(input logic [FIELD_W-1:0] v, input int n);
    repeat (n) drv.push_back(v);
  endtask

  // Start a check, play drv, hold the last value for tail cycles, score all outputs.
  task automatic run_seq(input string tag, input int len, input int tmo, input int tail);
    int s, es;
    logic eb, ep, ef;
    logic [1:0] ec;
    bus.seq_len_i = 4'(len);
    bus.tmo_i     = TMO_W'(tmo);
    bus.start_i   = 1'b1;
    s = hist.size();
    tick(cur);
    bus.start_i = 1'b0;
    foreach (drv[i]) tick(drv[i]);
    repeat (tail) tick(cur);
    model(s, hist.size() - 1 - s, len, tmo, eb, ep, ef, ec, es);
    chk({tag, ".busy"}, 32'(bus.busy_o), 32'(eb));
    chk({tag, ".pass"}, 32'(bus.pass_o), 32'(ep));
    chk({tag, ".fail"}, 32'(bus.fail_o), 32'(ef));
    chk({tag, ".code"}, 32'(bus.fail_code_o), 32'(ec));
    chk({tag, ".step"}, 32'(bus.step_o), 32'(es));
  endtask

  initial begin
    int len, tmo;
    rst            = 1'b1;
    bus.field_i    = '0;
    bus.exp_we_i   = 1'b0;
    bus.exp_addr_i = '0;
    bus.exp_data_i = '0;
    bus.seq_len_i  = '0;
    bus.tmo_i      = '0;
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
    repeat (4) tick(5'd0);
    rst = 1'b0;
    tick(5'd0);

    // Reset state
    chk("rst.busy", 32'(bus.busy_o), 32'd0);
    chk("rst.pass", 32'(bus.pass_o), 32'd0);
    chk("rst.fail", 32'(bus.fail_o), 32'd0);
    chk("rst.code", 32'(bus.fail_code_o), 32'd0);
    chk("rst.step", 32'(bus.step_o), 32'd0);

    // Basic pass: {00,02,01}
    for (int i = 0; i < DEPTH; i++) mexp[i] = 5'h1f;
    mexp[0] = 5'h00; mexp[1] = 5'h02; mexp[2] = 5'h01;
    load_all();
    tick(5'h10);
    tick(5'h10);
    drv.delete(); push_n(5'h00, 10); push_n(5'h02, 10); push_n(5'h01, 10);
    run_seq("t1", 3, 1000, 4);
    chk("t1.pass_c", 32'(bus.pass_o), 32'd1);
    chk("t1.step_c", 32'(bus.step_o), 32'd2);
    chk("t1.fail_c", 32'(bus.fail_o), 32'd0);

    // Timeout while waiting for entry 2
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 10); push_n(5'h02, 10);
    run_seq("t2", 3, 50, 80);
    chk("t2.fail_c", 32'(bus.fail_o), 32'd1);
    chk("t2.code_c", 32'(bus.fail_code_o), 32'd1);
    chk("t2.step_c", 32'(bus.step_o), 32'd2);

    // One-cycle glitch must not advance, then a clean resend passes
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 10); push_n(5'h02, 1); push_n(5'h01, 10);
    run_seq("t3", 3, 0, 5);
    chk("t3.step_c", 32'(bus.step_o), 32'd1);
`ifdef IO_SEQ_CHK_STRICT_EN
    chk("t3.code_c", 32'(bus.fail_code_o), 32'd3);
`else
    chk("t3.busy_c", 32'(bus.busy_o), 32'd1);
`endif
    drv.delete(); push_n(5'h02, 10); push_n(5'h00, 10); push_n(5'h02, 10); push_n(5'h01, 10);
    run_seq("t3b", 3, 0, 4);
    chk("t3b.pass_c", 32'(bus.pass_o), 32'd1);

    // Bad lengths fail on the edge after start
    drv.delete();
    run_seq("t4a", 0, 100, 0);
    chk("t4a.code_c", 32'(bus.fail_code_o), 32'd2);
    run_seq("t4b", 9, 100, 0);
    chk("t4b.fail_c", 32'(bus.fail_o), 32'd1);

    // Abort mid-check; a write while armed is dropped
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 10);
    run_seq("t5", 3, 0, 0);
    chk("t5.step_c", 32'(bus.step_o), 32'd1);
    bus.exp_we_i   = 1'b1;
    bus.exp_addr_i = 3'd1;
    bus.exp_data_i = 5'h05;
    tick(cur);
    bus.exp_we_i = 1'b0;
    abort_pulse();
    chk("t5.abort_busy", 32'(bus.busy_o), 32'd0);
    chk("t5.abort_pass", 32'(bus.pass_o), 32'd0);
    chk("t5.abort_fail", 32'(bus.fail_o), 32'd0);
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 6); push_n(5'h02, 6); push_n(5'h01, 6);
    run_seq("t5b", 3, 0, 4);
    chk("t5b.pass_c", 32'(bus.pass_o), 32'd1);

    // Stray stable value after the first match
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 10); push_n(5'h07, 3); push_n(5'h00, 6);
    run_seq("t6", 3, 0, 0);
    chk("t6.step_c", 32'(bus.step_o), 32'd1);
`ifdef IO_SEQ_CHK_STRICT_EN
    chk("t6.code_c", 32'(bus.fail_code_o), 32'd3);
`else
    chk("t6.fail_c", 32'(bus.fail_o), 32'd0);
`endif

    // Reset in the middle of a check
    tick(5'h10); tick(5'h10);
    drv.delete(); push_n(5'h00, 8);
    run_seq("t7", 3, 0, 0);
    rst = 1'b1;
    tick(cur);
    rst = 1'b0;
    chk("t7.rst_busy", 32'(bus.busy_o), 32'd0);
    chk("t7.rst_step", 32'(bus.step_o), 32'd0);
    chk("t7.rst_fail", 32'(bus.fail_o), 32'd0);

    // Randomized lists and waveforms
    for (int trial = 0; trial < 30; trial++) begin
      for (int i = 0; i < DEPTH; i++) mexp[i] = 5'($urandom_range(0, 3));
      load_all();
      len = $urandom_range(1, DEPTH);
      tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 40);
      drv.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) drv.push_back(5'($urandom_range(0, 31)));
        push_n(mexp[i], $urandom_range(1, 5));
      end
      run_seq($sformatf("rnd%0d", trial), len, tmo, 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
